// File: rtl/mux_pkg.sv
// Shared constants for the registered N:1 stream multiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mux_pkg;

  // Selection mode encoding carried on i_mode.
  localparam logic MODE_CMD = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Index width that stays legal for any input count of two or more.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin request picker: lowest requester at or above ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is consumed.
module rr_arbiter_n
  import mux_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = idx_width(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              found
);

  int cand;

  // Walk offsets 0..NUM_IN-1 from ptr; the first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      cand = (int'(ptr) + i) % NUM_IN;
      for (int j = 0; j < NUM_IN; j++) begin
        if (!found && (j == cand) && req[j]) begin
          found     = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mux_seq_n_1.sv
// Registered N:1 stream mux, command-selected or round-robin, one output register.
// Latency: one cycle from input transfer to o_valid/o_data_bus.
// Backpressure: o_ready only when the output slot frees this edge; holds while i_ready=0.
module mux_seq_n_1
  import mux_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 4,
  parameter int CMD_WIDTH  = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            i_valid,
  input  logic [NUM_IN*DATA_WIDTH-1:0] i_data_bus,
  output logic [NUM_IN-1:0]            o_ready,
  output logic                         o_valid,
  output logic [DATA_WIDTH-1:0]        o_data_bus,
  input  logic                         i_ready,
  input  logic                         i_en,
  input  logic                         i_mode,
  input  logic [CMD_WIDTH-1:0]         i_cmd
);

  localparam int IDX_W = idx_width(NUM_IN);

  logic [IDX_W-1:0]      rr_ptr;
  logic [NUM_IN-1:0]     rr_grant;
  logic [IDX_W-1:0]      rr_idx;
  logic                  rr_found;
  logic                  grant_vld;
  logic [IDX_W-1:0]      grant_idx;
  logic                  slot_free;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_word;
  logic [IDX_W-1:0]      ptr_next;

  rr_arbiter_n #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req       (i_valid),
    .ptr       (rr_ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .found     (rr_found)
  );

  // Pick the grant source; out-of-range or idle commands yield no grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (i_mode == MODE_RR) begin
      grant_vld = rr_found;
      grant_idx = rr_idx;
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        if ((int'(i_cmd) == k) && i_valid[k]) begin
          grant_vld = 1'b1;
          grant_idx = IDX_W'(k);
        end
      end
    end
  end

  // Accept only when the register can take a word this edge; reset forces no accept.
  always_comb begin
    slot_free = !o_valid || i_ready;
    accept    = !rst && i_en && slot_free && grant_vld;
    o_ready   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      o_ready[k] = accept && (grant_idx == IDX_W'(k));
    end
  end

  // Route the granted input word and compute the wrapped pointer successor.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (grant_idx == IDX_W'(k)) begin
        sel_word = i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    ptr_next = (grant_idx == IDX_W'(NUM_IN - 1)) ? '0 : grant_idx + IDX_W'(1);
  end

  // Output register and round-robin pointer; accept wins over drain on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_data_bus <= '0;
      rr_ptr     <= '0;
    end else if (accept) begin
      o_valid    <= 1'b1;
      o_data_bus <= sel_word;
      if (i_mode == MODE_RR) begin
        rr_ptr <= ptr_next;
      end
    end else if (o_valid && i_ready) begin
      o_valid    <= 1'b0;
      o_data_bus <= '0;
    end
  end

endmodule

// File: tb/tb_mux_seq_n_1.sv
// Self-checking bench for mux_seq_n_1: directed plan steps then random traffic vs a model.
// Latency: checks outputs each cycle between edges.
// Backpressure: model tracks held word, drain and accept.
module tb_mux_seq_n_1;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int CW = 3;

  logic            clk;
  logic            rst;
  logic [N-1:0]    i_valid;
  logic [N*DW-1:0] i_data_bus;
  logic [N-1:0]    o_ready;
  logic            o_valid;
  logic [DW-1:0]   o_data_bus;
  logic            i_ready;
  logic            i_en;
  logic            i_mode;
  logic [CW-1:0]   i_cmd;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: what the output register should hold and where RR search starts.
  bit          m_known = 0;
  bit          m_valid;
  logic [DW-1:0] m_data;
  int          m_ptr;

  mux_seq_n_1 #(.DATA_WIDTH(DW), .NUM_IN(N), .CMD_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus),
    .i_ready    (i_ready),
    .i_en       (i_en),
    .i_mode     (i_mode),
    .i_cmd      (i_cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Which input the rules grant right now, or -1 for none.
  function automatic int exp_grant();
    if (i_mode == 1'b0) begin
      if (int'(i_cmd) < N && i_valid[i_cmd[1:0]]) return int'(i_cmd);
      return -1;
    end
    for (int i = 0; i < N; i++) begin
      if (i_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic bit exp_accept(input int g);
    return !rst && i_en && (!m_valid || i_ready) && (g >= 0);
  endfunction

  // One clock: inputs already applied after a falling edge; check, clock, advance model.
  task automatic cycle();
    int g;
    bit acc;
    logic [N-1:0] want;
    #1;
    g    = exp_grant();
    acc  = exp_accept(g);
    want = acc ? (N'(1) << g) : '0;
    chk("o_ready", DW'(o_ready), DW'(want));
    if (m_known) begin
      chk("o_valid", DW'(o_valid), DW'(m_valid));
      chk("o_data", o_data_bus, m_data);
    end
    @(posedge clk);
    if (rst) begin
      m_known = 1;
      m_valid = 0;
      m_data  = '0;
      m_ptr   = 0;
    end else if (acc) begin
      m_valid = 1;
      m_data  = i_data_bus[g*DW +: DW];
      if (i_mode) m_ptr = (g + 1) % N;
    end else if (m_valid && i_ready) begin
      m_valid = 0;
      m_data  = '0;
    end
    @(negedge clk);
  endtask

  task automatic peek_ready(input string tag, input logic [N-1:0] exp);
    #1;
    chk(tag, DW'(o_ready), DW'(exp));
  endtask

  initial begin
    @(negedge clk);
    i_data_bus = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    i_valid = 4'hF; i_ready = 1; i_en = 1; i_mode = 1; i_cmd = 0;

    // Reset with every source asserting valid.
    rst = 1;
    cycle();
    cycle();
    chk("rst_valid", DW'(o_valid), 0);
    chk("rst_data", o_data_bus, 0);
    chk("rst_ready", DW'(o_ready), 0);

    // Round robin, all valid: 0,1,2,3,0 with a word every cycle.
    rst = 0;
    peek_ready("rr_g0", 4'b0001); cycle();
    chk("rr_first_word", o_data_bus, 32'hA0);
    peek_ready("rr_g1", 4'b0010); cycle();
    peek_ready("rr_g2", 4'b0100); cycle();
    peek_ready("rr_g3", 4'b1000); cycle();
    chk("rr_stream_valid", DW'(o_valid), 1);
    peek_ready("rr_g0b", 4'b0001); cycle();
    chk("rr_wrap_word", o_data_bus, 32'hA0);

    // Backpressure: word held, no grant, pointer frozen.
    i_ready = 0;
    repeat (3) begin
      peek_ready("bp_ready", 4'b0000); cycle();
      chk("bp_hold", o_data_bus, 32'hA0);
    end
    i_ready = 1;
    peek_ready("bp_release", 4'b0010); cycle();
    chk("bp_next_word", o_data_bus, 32'hA1);

    // Enable low: held word drains, nothing new until enabled.
    i_en = 0;
    peek_ready("en_off", 4'b0000); cycle();
    chk("en_drain_valid", DW'(o_valid), 0);
    chk("en_drain_data", o_data_bus, 0);
    peek_ready("en_off2", 4'b0000); cycle();
    i_en = 1;
    peek_ready("en_on", 4'b0100); cycle();

    // Command mode: select input 2, then out-of-range selector.
    i_mode = 0; i_cmd = 2;
    peek_ready("cmd2", 4'b0100); cycle();
    chk("cmd2_word", o_data_bus, 32'hA2);
    i_cmd = 5;
    peek_ready("cmd5", 4'b0000); cycle();
    chk("cmd5_drain", DW'(o_valid), 0);

    // Sparse round robin: park pointer at 2 via input 1, then 3,1,3 with a mode detour.
    i_mode = 1; i_valid = 4'b0010;
    peek_ready("sp_park", 4'b0010); cycle();
    i_valid = 4'b1010;
    peek_ready("sp_g3", 4'b1000); cycle();
    peek_ready("sp_g1", 4'b0010); cycle();
    i_mode = 0; i_cmd = 0;
    peek_ready("sp_cmd_idle", 4'b0000); cycle();
    i_mode = 1;
    peek_ready("sp_g3b", 4'b1000); cycle();

    // Reset while a word is held discards it.
    i_ready = 0;
    rst = 1;
    peek_ready("rst_mid", 4'b0000); cycle();
    chk("rst_mid_valid", DW'(o_valid), 0);
    rst = 0; i_ready = 1;

    // Random traffic against the model.
    for (int t = 0; t < 600; t++) begin
      i_valid    = N'($urandom);
      i_data_bus = {$urandom, $urandom, $urandom, $urandom};
      i_ready    = ($urandom_range(0, 3) != 0);
      i_en       = ($urandom_range(0, 7) != 0);
      i_mode     = ($urandom_range(0, 3) != 0);
      i_cmd      = CW'($urandom);
      rst        = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
